pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central stall/flush controller for the 5-stage integer pipeline. It detects load-use hazards between the ID-stage instruction and the load in EX, and sequences fixed-latency multi-cycle EX operations (divide) with an internal counter. It also merges the MEM wait request and the EX branch-redirect flush into one per-register stall vector plus a flush strobe, which drive the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- MC_LATENCY, 32: cycles a multi-cycle EX op needs before its result is valid; legal range 2..64.
- CNT_W, 6: multi-cycle counter width; must satisfy 2^CNT_W ≥ MC_LATENCY.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_reg_read_en_1  in  1  ID reads source 1.
- id_reg_addr_1  in  5  ID source 1 register.
- id_reg_read_en_2  in  1  ID reads source 2.
- id_reg_addr_2  in  5  ID source 2 register.
- id_write_reg_en  in  1  ID instruction writes a register.
- id_write_reg_addr  in  5  ID destination register.
- id_mem_read  in  1  ID instruction is a load.
- ex_mc_op  in  1  instruction currently in EX is multi-cycle.
- mem_stall_req  in  1  MEM stage waiting on memory (level).
- flush_req  in  1  EX redirect; level, held by source until `flush` seen.
- stall  out  5  hold per register: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB.
- flush  out  1  clear IF/ID and ID/EX to NOP this cycle; PC takes redirect.
- mc_start  out  1  one-cycle pulse: multi-cycle unit begins.
- mc_done  out  1  one-cycle pulse: multi-cycle result valid, EX may advance.
- perf_stall_cnt  out  32  stall-cycle counter (see Configuration).
- perf_flush_cnt  out  32  flush counter (see Configuration).

## Operation
- Stall semantics: a register with its stall bit set holds its contents. A register k with stall[k]=0 and stall[k-1]=1 loads a NOP bubble.
- EX load tracker: ex_load_vld and ex_load_addr[4:0] update when stall[2]=0.
  - Cleared on flush, or when a bubble enters ID/EX (stall[1]=1).
  - Otherwise loaded with id_mem_read & id_write_reg_en & (id_write_reg_addr≠0), and id_write_reg_addr.
- load_use = ex_load_vld & ((id_reg_read_en_1 & id_reg_addr_1==ex_load_addr) | (id_reg_read_en_2 & id_reg_addr_2==ex_load_addr)).
- Multi-cycle FSM, states RUN / MC_WAIT / MC_DONE:
  - RUN, ex_mc_op=1: mc_start=1, cnt←MC_LATENCY-2, go to MC_WAIT.
  - MC_WAIT: cnt decrements each cycle; at cnt==0 go to MC_DONE.
  - MC_DONE: mc_done=1 in the first cycle only. Stay until stall[3]=0, then go to RUN.
  - The counter runs regardless of mem_stall_req.
- mc_hold = ex_mc_op & (state≠MC_DONE).
- stall priority, highest first:
  - mem_stall_req → 5'b01111.
  - mc_hold → 5'b00111.
  - flush_req → 5'b00000.
  - load_use → 5'b00011.
  - otherwise 5'b00000.
- flush = flush_req & ~mem_stall_req & ~mc_hold. A flush suppresses the load-use stall because the ID instruction is killed.
- Register address 0 never produces a hazard.

## Timing
- stall, flush, mc_start are combinational from inputs and current state; no added latency.
- Load-use: exactly 1 stall cycle; the bubble reaches EX and the tracker clears.
- Multi-cycle op: enters EX in cycle T. mc_start at T, mc_done at T+MC_LATENCY-1, EX/MEM captures at T+MC_LATENCY-1 if MEM is not stalled.
- mem_stall_req during MC_WAIT: the count continues. If stalled at MC_DONE, state holds, mc_done does not repeat, and mc_hold stays 0.
- Reset (mid-operation included): state=RUN, cnt=0, ex_load_vld=0, ex_load_addr=0, stall=0, flush=0, mc_start=0, mc_done=0, perf counters=0.
- Simultaneous load_use and mc_hold: mc_hold wins. The ID instruction is held in place and re-evaluated after.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - perf_stall_cnt increments on every cycle with stall[0]=1.
  - perf_flush_cnt increments on every cycle with flush=1.
  - Both wrap at 2^32 and clear on reset.
- PIPE_PERF_CNT_EN undefined: both outputs are constant 0 and no counter flops exist.

## Test plan
- Load-use: load into r8 in ID then r8 read next cycle → the next instruction sees stall=5'b00011 for 1 cycle, then 0; ID/EX gets one bubble.
- Load into r0, then r0 read → no stall.
- MC_LATENCY=32, ex_mc_op raised at cycle 10 → mc_start at 10, stall=5'b00111 in cycles 10–40, mc_done at 41 with stall=0, RUN at 42.
- mem_stall_req high cycles 20–45 during the same op → stall=5'b01111 throughout; mc_done pulses once at 41; FSM leaves MC_DONE at 46.
- flush_req with load_use asserted → flush=1, stall=0. flush_req during mem_stall_req → flush=0 until the stall releases, then 1.
- rst pulse in MC_WAIT with cnt=12 → next cycle state RUN, stall=0, mc_done never pulses. With PIPE_PERF_CNT_EN, perf_stall_cnt reads 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central stall/flush controller for the 5-stage integer pipeline.
//
// Detects load-use hazards between the ID instruction and a load in EX.
// Sequences fixed-latency multi-cycle EX ops with a down-counter.
// Merges the MEM wait and the EX redirect into one per-register stall vector
// plus a flush strobe.
//
// Optional feature: define PIPE_PERF_CNT_EN to build the stall/flush
// performance counters. Without it, both perf outputs are tied to zero.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_reg_read_en_1/2       ID source operand read enables
//   id_reg_addr_1/2          ID source register addresses
//   id_write_reg_en/addr     ID destination write enable / address
//   id_mem_read              ID instruction is a load
//   ex_mc_op                 EX instruction is multi-cycle
//   mem_stall_req            MEM waiting on memory (level)
//   flush_req                EX redirect (level, held until flush seen)
//   stall[4:0]               hold: [0] PC [1] IF/ID [2] ID/EX [3] EX/MEM [4] MEM/WB
//   flush                    clear IF/ID and ID/EX, PC takes redirect
//   mc_start, mc_done        multi-cycle begin / result-valid pulses
//   perf_stall_cnt           cycles with stall[0]=1
//   perf_flush_cnt           cycles with flush=1
module pipeline_ctrl #(
  parameter int unsigned MC_LATENCY = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_reg_read_en_1,
  input  logic [4:0]  id_reg_addr_1,
  input  logic        id_reg_read_en_2,
  input  logic [4:0]  id_reg_addr_2,
  input  logic        id_write_reg_en,
  input  logic [4:0]  id_write_reg_addr,
  input  logic        id_mem_read,
  input  logic        ex_mc_op,
  input  logic        mem_stall_req,
  input  logic        flush_req,
  output logic [4:0]  stall,
  output logic        flush,
  output logic        mc_start,
  output logic        mc_done,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {StRun, StMcWait, StMcDone} state_e;

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(MC_LATENCY - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_first_q, done_first_d;
  logic             ex_load_vld_q;
  logic [4:0]       ex_load_addr_q;
  logic             load_use;
  logic             mc_hold;

  assign load_use = ex_load_vld_q &
                    ((id_reg_read_en_1 & (id_reg_addr_1 == ex_load_addr_q)) |
                     (id_reg_read_en_2 & (id_reg_addr_2 == ex_load_addr_q)));

  assign mc_hold = ex_mc_op & (state_q != StMcDone);

  // Stall vector and flush strobe, highest priority first.
  always_comb begin
    stall = 5'b00000;
    if (mem_stall_req) begin
      stall = 5'b01111;
    end else if (mc_hold) begin
      stall = 5'b00111;
    end else if (flush_req) begin
      stall = 5'b00000;  // ID instruction is killed, so no load-use stall
    end else if (load_use) begin
      stall = 5'b00011;
    end
    flush = flush_req & ~mem_stall_req & ~mc_hold;
  end

  // Multi-cycle sequencer. WAIT covers count values CntInit..1, so DONE is
  // entered MC_LATENCY-1 cycles after the op reached EX.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    done_first_d = 1'b0;
    mc_start     = 1'b0;
    case (state_q)
      StRun: begin
        if (ex_mc_op) begin
          mc_start = 1'b1;
          cnt_d    = CntInit;
          if (CntInit == '0) begin
            state_d      = StMcDone;
            done_first_d = 1'b1;
          end else begin
            state_d = StMcWait;
          end
        end
      end
      StMcWait: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d      = StMcDone;
          done_first_d = 1'b1;
        end
      end
      StMcDone: begin
        if (!stall[3]) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Only the first DONE cycle pulses, even if MEM holds us there.
  assign mc_done = (state_q == StMcDone) & done_first_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      done_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_first_q <= done_first_d;
    end
  end

  // Tracks whether the instruction now in EX is a load and its destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_load_vld_q  <= 1'b0;
      ex_load_addr_q <= 5'd0;
    end else if (!stall[2]) begin
      if (flush || stall[1]) begin
        ex_load_vld_q  <= 1'b0;
        ex_load_addr_q <= 5'd0;
      end else begin
        ex_load_vld_q  <= id_mem_read & id_write_reg_en & (id_write_reg_addr != 5'd0);
        ex_load_addr_q <= id_write_reg_addr;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (stall[0]) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)    perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes the expected per-cycle
// response; a monitor on the falling edge pops and compares.
module tb_pipeline_ctrl;

  logic        clk = 1'b1;
  logic        rst;
  logic        id_reg_read_en_1, id_reg_read_en_2;
  logic [4:0]  id_reg_addr_1, id_reg_addr_2;
  logic        id_write_reg_en;
  logic [4:0]  id_write_reg_addr;
  logic        id_mem_read;
  logic        ex_mc_op;
  logic        mem_stall_req;
  logic        flush_req;
  logic [4:0]  stall;
  logic        flush, mc_start, mc_done;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MC_LATENCY(32), .CNT_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .id_reg_read_en_1  (id_reg_read_en_1),
    .id_reg_addr_1     (id_reg_addr_1),
    .id_reg_read_en_2  (id_reg_read_en_2),
    .id_reg_addr_2     (id_reg_addr_2),
    .id_write_reg_en   (id_write_reg_en),
    .id_write_reg_addr (id_write_reg_addr),
    .id_mem_read       (id_mem_read),
    .ex_mc_op          (ex_mc_op),
    .mem_stall_req     (mem_stall_req),
    .flush_req         (flush_req),
    .stall             (stall),
    .flush             (flush),
    .mc_start          (mc_start),
    .mc_done           (mc_done),
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_flush_cnt    (perf_flush_cnt)
  );

  typedef struct packed {
    logic       chk;
    logic       rst;
    logic [7:0] tag;
    logic [4:0] stall;
    logic       flush;
    logic       start;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   tag   = 0;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  // Monitor: running totals of expected stall/flush cycles model the perf counters.
  exp_t        e;
  logic [31:0] acc_stall = 32'd0;
  logic [31:0] acc_flush = 32'd0;
  logic [31:0] want_ps, want_pf;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.rst) begin
        acc_stall = 32'd0;
        acc_flush = 32'd0;
      end else if (e.chk) begin
        tests++;
        if ({stall, flush, mc_start, mc_done} !== {e.stall, e.flush, e.start, e.done}) begin
          fails++;
          $display("FAIL ctrl tag=%0d t=%0t got stall=%b flush=%b start=%b done=%b want stall=%b flush=%b start=%b done=%b",
                   e.tag, $time, stall, flush, mc_start, mc_done,
                   e.stall, e.flush, e.start, e.done);
        end
        want_ps = PerfEn ? acc_stall : 32'd0;
        want_pf = PerfEn ? acc_flush : 32'd0;
        tests++;
        if (perf_stall_cnt !== want_ps || perf_flush_cnt !== want_pf) begin
          fails++;
          $display("FAIL perf tag=%0d t=%0t got stall_cnt=%0d flush_cnt=%0d want %0d %0d",
                   e.tag, $time, perf_stall_cnt, perf_flush_cnt, want_ps, want_pf);
        end
        acc_stall = acc_stall + {31'd0, e.stall[0]};
        acc_flush = acc_flush + {31'd0, e.flush};
      end
    end
  end

  task automatic id_set(input logic r1, input logic [4:0] a1, input logic r2,
                        input logic [4:0] a2, input logic we, input logic [4:0] wa,
                        input logic ld);
    id_reg_read_en_1  = r1;
    id_reg_addr_1     = a1;
    id_reg_read_en_2  = r2;
    id_reg_addr_2     = a2;
    id_write_reg_en   = we;
    id_write_reg_addr = wa;
    id_mem_read       = ld;
  endtask

  task automatic id_idle();
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic id_load(input logic [4:0] rd);
    id_set(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, rd, 1'b1);
  endtask

  // One clock with the current inputs and the expected response.
  task automatic cyc(input logic [4:0] s, input logic f, input logic st, input logic dn);
    exp_t x;
    x = '{chk: 1'b1, rst: 1'b0, tag: 8'(tag), stall: s, flush: f, start: st, done: dn};
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cyc();
    exp_t x;
    rst = 1'b1;
    x = '{chk: 1'b0, rst: 1'b1, tag: 8'(tag), stall: 5'd0, flush: 1'b0, start: 1'b0,
          done: 1'b0};
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ex_mc_op = 1'b0;
    mem_stall_req = 1'b0;
    flush_req = 1'b0;
    id_idle();
    rst_cyc();
    rst_cyc();

    // Reset state.
    tag = 1;
    cyc(5'b00000, 0, 0, 0);

    // Load r8 then read r8 on source 1: one stall, then the bubble clears it.
    tag = 2;
    id_load(5'd8);                                      cyc(5'b00000, 0, 0, 0);
    id_set(1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);   cyc(5'b00011, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);
    id_idle();                                          cyc(5'b00000, 0, 0, 0);

    // Same hazard through source 2.
    tag = 3;
    id_load(5'd5);                                      cyc(5'b00000, 0, 0, 0);
    id_set(1'b1, 5'd3, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);   cyc(5'b00011, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);

    // Matching addresses with read enables low: no hazard.
    tag = 4;
    id_load(5'd5);                                      cyc(5'b00000, 0, 0, 0);
    id_set(1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);   cyc(5'b00000, 0, 0, 0);

    // Load into r0 then read r0: never a hazard.
    tag = 5;
    id_load(5'd0);                                      cyc(5'b00000, 0, 0, 0);
    id_set(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);   cyc(5'b00000, 0, 0, 0);

    // Flush wins over load-use and clears the tracker.
    tag = 6;
    id_load(5'd9);                                      cyc(5'b00000, 0, 0, 0);
    id_set(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    flush_req = 1'b1;                                   cyc(5'b00000, 1, 0, 0);
    flush_req = 1'b0;                                   cyc(5'b00000, 0, 0, 0);
    id_idle();

    // Flush held off by a MEM stall, then taken when it releases.
    tag = 7;
    flush_req = 1'b1;
    mem_stall_req = 1'b1;                               cyc(5'b01111, 0, 0, 0);
    cyc(5'b01111, 0, 0, 0);
    mem_stall_req = 1'b0;                               cyc(5'b00000, 1, 0, 0);
    flush_req = 1'b0;                                   cyc(5'b00000, 0, 0, 0);

    // Multi-cycle op with a pending load-use: mc_hold wins until done, then
    // the ID instruction is re-evaluated and stalls once.
    tag = 8;
    id_load(5'd7);                                      cyc(5'b00000, 0, 0, 0);
    id_set(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    ex_mc_op = 1'b1;                                    cyc(5'b00111, 0, 1, 0);
    for (int i = 1; i <= 30; i++)                       cyc(5'b00111, 0, 0, 0);
    cyc(5'b00011, 0, 0, 1);
    ex_mc_op = 1'b0;                                    cyc(5'b00000, 0, 0, 0);
    id_idle();                                          cyc(5'b00000, 0, 0, 0);

    // Multi-cycle op overlapped by a MEM stall on relative cycles 10..35.
    tag = 9;
    ex_mc_op = 1'b1;                                    cyc(5'b00111, 0, 1, 0);
    for (int i = 1; i <= 9; i++)                        cyc(5'b00111, 0, 0, 0);
    mem_stall_req = 1'b1;
    for (int i = 10; i <= 30; i++)                      cyc(5'b01111, 0, 0, 0);
    cyc(5'b01111, 0, 0, 1);
    for (int i = 32; i <= 35; i++)                      cyc(5'b01111, 0, 0, 0);
    mem_stall_req = 1'b0;                               cyc(5'b00000, 0, 0, 0);

    // Back in RUN: a new op starts, then reset lands when the count is 12.
    tag = 10;
    cyc(5'b00111, 0, 1, 0);
    for (int i = 1; i <= 18; i++)                       cyc(5'b00111, 0, 0, 0);
    ex_mc_op = 1'b0;
    rst_cyc();
    for (int i = 0; i < 40; i++)                        cyc(5'b00000, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
